// File: rtl/hpdmc_refresh_sched.sv
// hpdmc_refresh_sched: autonomous SDRAM refresh scheduler.
// It counts refresh intervals and keeps a count of owed refreshes (debt).
// It requests the command bus and, once the bus is granted, issues
// PRECHARGE ALL followed by a burst of AUTO REFRESH commands until the debt is paid.
module hpdmc_refresh_sched #(
    parameter int MAX_DEBT = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sdram_rst,
    input  logic        bypass,
    input  logic [2:0]  tim_rp,
    input  logic [3:0]  tim_rfc,
    input  logic [10:0] tim_refi,
    output logic        ref_req,
    input  logic        ref_ack,
    output logic        cmd_valid,
    output logic        cmd_cs_n,
    output logic        cmd_we_n,
    output logic        cmd_cas_n,
    output logic        cmd_ras_n,
    output logic [12:0] cmd_adr,
    output logic [1:0]  cmd_ba,
    output logic        ref_busy,
    output logic        ref_done,
    output logic        overrun
);

    localparam logic [3:0] MAX_DEBT_L = 4'(MAX_DEBT);

    typedef enum logic [2:0] {
        S_IDLE, S_PRECH, S_WAIT_RP, S_AUTOREF, S_WAIT_RFC, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] timer_q, timer_d;
    logic [3:0]  debt_q, debt_d;
    logic [3:0]  wait_q, wait_d;
    logic        ref_req_q, ref_req_d;
    logic        overrun_q, overrun_d;

    logic [2:0]  rp_eff;
    logic [3:0]  rfc_eff;
    logic [10:0] refi_eff;
    logic        expire;
    logic        autoref;

    // Zero timing fields behave as one cycle
    always_comb begin
        rp_eff   = (tim_rp   == 3'd0)  ? 3'd1  : tim_rp;
        rfc_eff  = (tim_rfc  == 4'd0)  ? 4'd1  : tim_rfc;
        refi_eff = (tim_refi == 11'd0) ? 11'd1 : tim_refi;
    end

    // Interval timer: an expiry fires every refi_eff active cycles; bypass freezes it
    always_comb begin
        expire  = !bypass && (timer_q <= 11'd1);
        timer_d = timer_q;
        if (!bypass)
            timer_d = expire ? refi_eff : timer_q - 11'd1;
    end

    // Debt bookkeeping: an expiry and an AUTOREF in the same cycle cancel out
    always_comb begin
        autoref   = (state_q == S_AUTOREF);
        debt_d    = debt_q;
        overrun_d = overrun_q;
        if (expire && !autoref) begin
            if (debt_q == MAX_DEBT_L)
                overrun_d = 1'b1;
            else
                debt_d = debt_q + 4'd1;
        end else if (!expire && autoref && debt_q != 4'd0) begin
            debt_d = debt_q - 4'd1;
        end
    end

    // Bus request: raised in IDLE while debt is owed, dropped once the grant is taken
    always_comb begin
        ref_req_d = (state_q == S_IDLE) && (debt_q != 4'd0) && !bypass &&
                    !(ref_req_q && ref_ack);
    end

    // Sequencer next state. wait_q holds the remaining gap minus one, so the
    // next command lands exactly tim_* cycles after the previous one.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (ref_req_q && ref_ack)
                    state_d = S_PRECH;
            end
            S_PRECH: begin
                if (rp_eff == 3'd1) begin
                    state_d = bypass ? S_DONE : S_AUTOREF;
                end else begin
                    wait_d  = {1'b0, rp_eff} - 4'd1;
                    state_d = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                if (wait_q == 4'd1)
                    state_d = bypass ? S_DONE : S_AUTOREF;
                else
                    wait_d = wait_q - 4'd1;
            end
            S_AUTOREF: begin
                if (rfc_eff == 4'd1) begin
                    state_d = (debt_d != 4'd0 && !bypass) ? S_AUTOREF : S_DONE;
                end else begin
                    wait_d  = rfc_eff - 4'd1;
                    state_d = S_WAIT_RFC;
                end
            end
            S_WAIT_RFC: begin
                if (wait_q == 4'd1)
                    state_d = (debt_d != 4'd0 && !bypass) ? S_AUTOREF : S_DONE;
                else
                    wait_d = wait_q - 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command decode from the current state; NOP unless issuing
    always_comb begin
        cmd_valid = 1'b0;
        cmd_cs_n  = 1'b1;
        cmd_ras_n = 1'b1;
        cmd_cas_n = 1'b1;
        cmd_we_n  = 1'b1;
        cmd_adr   = 13'd0;
        cmd_ba    = 2'd0;
        if (state_q == S_PRECH) begin
            cmd_valid = 1'b1;
            cmd_cs_n  = 1'b0;
            cmd_ras_n = 1'b0;
            cmd_we_n  = 1'b0;
            cmd_adr   = 13'h0400;
        end else if (state_q == S_AUTOREF) begin
            cmd_valid = 1'b1;
            cmd_cs_n  = 1'b0;
            cmd_ras_n = 1'b0;
            cmd_cas_n = 1'b0;
        end
        ref_busy = (state_q != S_IDLE);
        ref_done = (state_q == S_DONE);
        ref_req  = ref_req_q;
        overrun  = overrun_q;
    end

    // State registers; sdram_rst aborts everything except the sticky overrun flag
    always_ff @(posedge sys_clk) begin
        if (sys_rst || sdram_rst) begin
            state_q   <= S_IDLE;
            timer_q   <= tim_refi;
            debt_q    <= 4'd0;
            wait_q    <= 4'd0;
            ref_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            debt_q    <= debt_d;
            wait_q    <= wait_d;
            ref_req_q <= ref_req_d;
        end
    end

    // Overrun is cleared only by the system reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            overrun_q <= 1'b0;
        else if (!sdram_rst)
            overrun_q <= overrun_d;
    end

endmodule
